// File: rtl/quadenc_tx_pkg.sv
// Shared constants for the quadrature encoder transmitter.
// Holds the controller state encoding, the timer width, and the Gray table
// that maps the two-bit phase index onto the (A,B) output pair.
// There are no ports; the top level and the timer import this package.
package quadenc_tx_pkg;

    // Controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The spacing timer must hold any SPACING value up to 65535
    localparam int unsigned TIMER_W = 32'd16;

    // Gray table: phase index -> {A,B}. Counting the index upwards gives the
    // "up" sequence 00 -> 10 -> 11 -> 01 -> 00.
    localparam logic [1:0] AB_PH0 = 2'b00;
    localparam logic [1:0] AB_PH1 = 2'b10;
    localparam logic [1:0] AB_PH2 = 2'b11;
    localparam logic [1:0] AB_PH3 = 2'b01;

    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = AB_PH0;
            2'd1:    ab = AB_PH1;
            2'd2:    ab = AB_PH2;
            2'd3:    ab = AB_PH3;
            default: ab = AB_PH0;
        endcase
        return ab;
    endfunction

    // One quadrature step. The index wraps modulo 4, so the sequence
    // continues from whatever phase the previous command left behind.
    function automatic logic [1:0] phase_step(input logic [1:0] phase,
                                              input logic       dir);
        logic [1:0] nxt;
        if (dir) begin
            nxt = phase + 2'd1;
        end else begin
            nxt = phase - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quadenc_timer.sv
// Spacing timer for the quadrature transmitter.
// It counts down from SPACING-1 to zero. While enable is high, tick is
// asserted for one cycle every SPACING cycles. A clear reloads the counter,
// so the first tick after a clear comes SPACING cycles later.
// Ports:
//   clk    - system clock (rising edge)
//   reset  - asynchronous active-low reset (counter forced to 0)
//   clear  - reload the counter to SPACING-1
//   enable - count while high, hold while low
//   tick   - one-cycle strobe when the count expires
module quadenc_timer
    import quadenc_tx_pkg::*;
#(
    parameter int unsigned SPACING = 32'd48
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [TIMER_W-1:0] RELOAD   = TIMER_W'(SPACING - 32'd1);
    localparam logic [TIMER_W-1:0] CNT_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] CNT_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

    logic [TIMER_W-1:0] count_r;
    logic [TIMER_W-1:0] count_nxt_s;

    assign tick = enable && (count_r == CNT_ZERO);

    // Next count: clear wins, then reload on expiry, otherwise decrement
    always_comb begin
        count_nxt_s = count_r;
        if (clear) begin
            count_nxt_s = RELOAD;
        end else if (enable) begin
            if (count_r == CNT_ZERO) begin
                count_nxt_s = RELOAD;
            end else begin
                count_nxt_s = count_r - CNT_ONE;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/quadenc_tx.sv
// Quadrature encoder transmitter.
// Each accepted command emits cmd_count*STEP quadrature edges on A/B in the
// requested direction, with one edge every SPACING clock cycles. The phase
// carries over from one command to the next.
// Ports:
//   clk        - system clock (rising edge)
//   reset      - asynchronous active-low reset
//   cmd_valid  - command offered
//   cmd_ready  - block is idle and can accept a command
//   cmd_dir    - 1 = up (decoder count increases), 0 = down
//   cmd_count  - detents to emit
//   abort      - stop the running command (ignored while idle)
//   A, B       - registered quadrature phases
//   busy       - a command is executing
//   remaining  - edges still to emit
//   done       - one-cycle pulse on completion or abort
module quadenc_tx
    import quadenc_tx_pkg::*;
#(
    parameter int unsigned BITS    = 32'd8,
    parameter int unsigned STEP    = 32'd2,
    parameter int unsigned SPACING = 32'd48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [BITS-1:0]   cmd_count,
    input  logic              abort,
    output logic              A,
    output logic              B,
    output logic              busy,
    output logic [BITS+7:0]   remaining,
    output logic              done
);

    localparam int unsigned REM_W = BITS + 32'd8;
    localparam logic [REM_W-1:0] REM_ZERO = {REM_W{1'b0}};
    localparam logic [REM_W-1:0] REM_ONE  = {{(REM_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic [1:0]       phase_r;
    logic [1:0]       phase_nxt_s;
    logic             a_r;
    logic             b_r;
    logic [REM_W-1:0] remaining_r;
    logic [REM_W-1:0] rem_nxt_s;
    logic [REM_W-1:0] rem_load_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             timer_clr_s;
    logic             timer_en_s;
    logic             tick_s;

    // Edge count is widened before the multiply so that no product is lost
    assign rem_load_s = REM_W'(cmd_count) * REM_W'(STEP);
    assign timer_en_s = (state_r == ST_RUN);

    quadenc_timer #(
        .SPACING (SPACING)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr_s),
        .enable (timer_en_s),
        .tick   (tick_s)
    );

    // Next-state logic: command acceptance, edge stepping, abort, completion
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        phase_nxt_s = phase_r;
        rem_nxt_s   = remaining_r;
        done_nxt_s  = 1'b0;
        timer_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_nxt_s = cmd_dir;
                    rem_nxt_s = rem_load_s;
                    if (cmd_count == {BITS{1'b0}}) begin
                        // Empty command completes at once without moving A/B
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                        timer_clr_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Abort wins over a coinciding edge; the phase is held
                    state_nxt_s = ST_IDLE;
                    rem_nxt_s   = REM_ZERO;
                    done_nxt_s  = 1'b1;
                end else if (tick_s) begin
                    phase_nxt_s = phase_step(phase_r, dir_r);
                    if (remaining_r <= REM_ONE) begin
                        state_nxt_s = ST_IDLE;
                        rem_nxt_s   = REM_ZERO;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                        rem_nxt_s   = remaining_r - REM_ONE;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            dir_r       <= 1'b0;
            phase_r     <= 2'd0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            remaining_r <= REM_ZERO;
            done_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dir_r        <= dir_nxt_s;
            phase_r      <= phase_nxt_s;
            {a_r, b_r}   <= phase_to_ab(phase_nxt_s);
            remaining_r  <= rem_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_RUN);
    assign A         = a_r;
    assign B         = b_r;
    assign remaining = remaining_r;
    assign done      = done_r;

endmodule

// File: tb/tb_quadenc_tx.sv
// Self-checking bench for quadenc_tx (BITS=8, STEP=2, SPACING=4).
// The reference model tracks an integer position. Edge e of a command lands
// exactly e*SPACING cycles after acceptance, and (A,B) is derived from the
// position modulo 4. A small quadrature decoder reads A/B as the loopback
// receiver and reports two counts per quadrature edge.
module tb_quadenc_tx;

    localparam int BITS      = 8;
    localparam int STEP      = 2;
    localparam int SPACING   = 4;
    localparam int DEC_SCALE = 2;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_dir   = 1'b0;
    logic              abort     = 1'b0;
    logic [BITS-1:0]   cmd_count = '0;
    logic              cmd_ready;
    logic              A;
    logic              B;
    logic              busy;
    logic              done;
    logic [BITS+7:0]   remaining;

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;
    int dec_count = 0;
    logic [1:0] dec_prev = 2'b00;
    logic [1:0] obs_ab [$];
    int         obs_rem [$];

    quadenc_tx #(.BITS(BITS), .STEP(STEP), .SPACING(SPACING)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .abort     (abort),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .remaining (remaining),
        .done      (done)
    );

    always #5 clk = ~clk;

    // (A,B) for a position: the cycle is 00,10,11,01
    function automatic logic [1:0] exp_ab(input int p);
        int m;
        m = ((p % 4) + 4) % 4;
        return {(m == 1 || m == 2), (m >= 2)};
    endfunction

    function automatic int ab_pos(input logic [1:0] ab);
        return int'(ab[1] ^ ab[0]) + 2 * int'(ab[0]);
    endfunction

    // Loopback decoder
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_count <= 0;
            dec_prev  <= 2'b00;
        end else begin
            if (((ab_pos({A, B}) - ab_pos(dec_prev) + 4) % 4) == 1)
                dec_count <= dec_count + DEC_SCALE;
            else if (((ab_pos({A, B}) - ab_pos(dec_prev) + 4) % 4) == 3)
                dec_count <= dec_count - DEC_SCALE;
            dec_prev <= {A, B};
        end
    end

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({A, B} !== 2'b00 || busy !== 1'b0 || remaining !== '0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: AB=%b busy=%b rem=%0d done=%b ready=%b, required AB=00 busy=0 rem=0 done=0 ready=1",
                     {A, B}, busy, remaining, done, cmd_ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({A, B} !== 2'b00 || busy !== 1'b0 || remaining !== '0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: AB=%b busy=%b rem=%0d done=%b ready=%b, required AB=00 busy=0 rem=0 done=0 ready=1",
                     {A, B}, busy, remaining, done, cmd_ready);
        end
        pos = 0;
    endtask

    // Issue one command and check every cycle against the timing model.
    // abort_after > 0 raises abort right after that many edges.
    task automatic test_command(input logic dir, input int count, input int abort_after, input string tag);
        int n;
        int e;
        int start;
        int limit;
        logic fin;
        n = count * STEP;
        start = pos;
        obs_ab.delete();
        obs_rem.delete();
        cmd_dir = dir; cmd_count = count[BITS-1:0]; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (n == 0) begin
            if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || {A, B} !== exp_ab(pos)) begin
                n_fail++;
                $display("FAIL %s accept: done=%b ready=%b busy=%b AB=%b, required done=1 ready=1 busy=0 AB=%b",
                         tag, done, cmd_ready, busy, {A, B}, exp_ab(pos));
            end
        end else begin
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || remaining !== (BITS+8)'(n) || done !== 1'b0 || {A, B} !== exp_ab(start)) begin
                n_fail++;
                $display("FAIL %s accept: busy=%b ready=%b rem=%0d done=%b AB=%b, required busy=1 ready=0 rem=%0d done=0 AB=%b",
                         tag, busy, cmd_ready, remaining, done, {A, B}, n, exp_ab(start));
            end
            obs_rem.push_back(int'(remaining));
            limit = (abort_after > 0) ? abort_after : n;
            for (int k = 1; k <= limit * SPACING; k++) begin
                @(posedge clk); #1;
                e = k / SPACING;
                pos = dir ? start + e : start - e;
                fin = (abort_after == 0 && k == n * SPACING);
                n_checks++;
                if ({A, B} !== exp_ab(pos) || remaining !== (BITS+8)'(n - e) || done !== fin || busy !== !fin || cmd_ready !== fin) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: AB=%b rem=%0d done=%b busy=%b ready=%b, required AB=%b rem=%0d done=%b busy=%b ready=%b",
                             tag, k, {A, B}, remaining, done, busy, cmd_ready, exp_ab(pos), n - e, fin, !fin, fin);
                end
                if (k % SPACING == 0) begin
                    obs_ab.push_back({A, B});
                    obs_rem.push_back(int'(remaining));
                end
            end
            if (abort_after > 0) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                n_checks++;
                if (done !== 1'b1 || remaining !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || {A, B} !== exp_ab(pos)) begin
                    n_fail++;
                    $display("FAIL %s abort: done=%b rem=%0d ready=%b busy=%b AB=%b, required done=1 rem=0 ready=1 busy=0 AB=%b",
                             tag, done, remaining, cmd_ready, busy, {A, B}, exp_ab(pos));
                end
            end
        end
        for (int k = 0; k < 2 * SPACING; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || {A, B} !== exp_ab(pos) || cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s after %0d: done=%b AB=%b ready=%b, required done=0 AB=%b ready=1",
                         tag, k, done, {A, B}, cmd_ready, exp_ab(pos));
            end
        end
    endtask

    task automatic test_basic_up();
        logic [1:0] want [6];
        want = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
        test_command(1'b1, 3, 0, "up3");
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs_ab.size() <= i || obs_ab[i] !== want[i]) begin
                n_fail++;
                $display("FAIL up3_seq edge %0d: AB=%b, required %b", i + 1, (obs_ab.size() > i) ? obs_ab[i] : 2'bxx, want[i]);
            end
        end
    endtask

    task automatic test_zero();
        test_command(1'b1, 0, 0, "zero");
    endtask

    task automatic test_down();
        logic [1:0] want_ab [4];
        int         want_rem [5];
        want_ab  = '{2'b10, 2'b00, 2'b01, 2'b11};
        want_rem = '{4, 3, 2, 1, 0};
        n_checks++;
        if ({A, B} !== 2'b11) begin
            n_fail++;
            $display("FAIL down2_start: AB=%b, required 11", {A, B});
        end
        test_command(1'b0, 2, 0, "down2");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_ab.size() <= i || obs_ab[i] !== want_ab[i]) begin
                n_fail++;
                $display("FAIL down2_seq edge %0d: AB=%b, required %b", i + 1, (obs_ab.size() > i) ? obs_ab[i] : 2'bxx, want_ab[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs_rem.size() <= i || obs_rem[i] != want_rem[i]) begin
                n_fail++;
                $display("FAIL down2_rem step %0d: rem=%0d, required %0d", i, (obs_rem.size() > i) ? obs_rem[i] : -1, want_rem[i]);
            end
        end
    endtask

    task automatic test_abort();
        test_command(1'b1, 5, 3, "abort3of10");
    endtask

    task automatic test_abort_final();
        int start;
        start = pos;
        cmd_dir = 1'b1; cmd_count = 8'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2 * SPACING - 1) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        pos = start + 1;
        n_checks++;
        if ({A, B} !== exp_ab(pos) || remaining !== '0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_final: AB=%b rem=%0d done=%b ready=%b, required AB=%b rem=0 done=1 ready=1",
                     {A, B}, remaining, done, cmd_ready, exp_ab(pos));
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || {A, B} !== exp_ab(pos)) begin
            n_fail++;
            $display("FAIL abort_final_after: done=%b AB=%b, required done=0 AB=%b", done, {A, B}, exp_ab(pos));
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || {A, B} !== exp_ab(pos)) begin
            n_fail++;
            $display("FAIL abort_idle: done=%b ready=%b busy=%b AB=%b, required done=0 ready=1 busy=0 AB=%b",
                     done, cmd_ready, busy, {A, B}, exp_ab(pos));
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int e;
        logic fin;
        start = pos;
        cmd_dir = 1'b1; cmd_count = 8'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 2 * SPACING; k++) begin
            @(posedge clk); #1;
            e = k / SPACING;
            fin = (k == 2 * SPACING);
            n_checks++;
            if ({A, B} !== exp_ab(start + e) || remaining !== (BITS+8)'(2 - e) || done !== fin || cmd_ready !== fin) begin
                n_fail++;
                $display("FAIL b2b_first cycle %0d: AB=%b rem=%0d done=%b ready=%b, required AB=%b rem=%0d done=%b ready=%b",
                         k, {A, B}, remaining, done, cmd_ready, exp_ab(start + e), 2 - e, fin, fin);
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || remaining !== 16'd2 || done !== 1'b0 || {A, B} !== exp_ab(start + 2)) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b rem=%0d done=%b AB=%b, required busy=1 rem=2 done=0 AB=%b",
                     busy, remaining, done, {A, B}, exp_ab(start + 2));
        end
        for (int k = 1; k <= 2 * SPACING + 1; k++) begin
            @(posedge clk); #1;
            e = (k / SPACING > 2) ? 2 : k / SPACING;
            fin = (k == 2 * SPACING);
            n_checks++;
            if ({A, B} !== exp_ab(start + 2 + e) || done !== fin) begin
                n_fail++;
                $display("FAIL b2b_second cycle %0d: AB=%b done=%b, required AB=%b done=%b",
                         k, {A, B}, done, exp_ab(start + 2 + e), fin);
            end
        end
        pos = start + 4;
    endtask

    task automatic test_random();
        logic dir;
        int   cnt;
        int   ab_at;
        for (int i = 0; i < 6; i++) begin
            dir = 1'($urandom_range(0, 1));
            cnt = int'($urandom_range(0, 4));
            ab_at = 0;
            if (cnt > 0 && $urandom_range(0, 2) == 0)
                ab_at = int'($urandom_range(1, cnt * STEP - 1));
            test_command(dir, cnt, ab_at, "random");
        end
    endtask

    task automatic test_loopback();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        pos = 0;
        @(posedge clk); #1;
        n_checks++;
        if (dec_count !== 0 || {A, B} !== 2'b00) begin
            n_fail++;
            $display("FAIL loop_start: count=%0d AB=%b, required count=0 AB=00", dec_count, {A, B});
        end
        test_command(1'b1, 5, 0, "loop_up");
        n_checks++;
        if (dec_count !== 20) begin
            n_fail++;
            $display("FAIL loop_up_count: count=%0d, required 20", dec_count);
        end
        test_command(1'b0, 5, 0, "loop_down");
        n_checks++;
        if (dec_count !== 0) begin
            n_fail++;
            $display("FAIL loop_down_count: count=%0d, required 0", dec_count);
        end
        cmd_dir = 1'b1; cmd_count = 8'd5; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3 * SPACING + 1) @(posedge clk);
        #3;
        n_checks++;
        if ({A, B} !== exp_ab(3) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_midrun: AB=%b busy=%b, required AB=%b busy=1", {A, B}, busy, exp_ab(3));
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({A, B} !== 2'b00 || busy !== 1'b0 || remaining !== '0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_reset: AB=%b busy=%b rem=%0d done=%b ready=%b, required AB=00 busy=0 rem=0 done=0 ready=1",
                     {A, B}, busy, remaining, done, cmd_ready);
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 2 * SPACING; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || {A, B} !== 2'b00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL loop_post_reset %0d: done=%b AB=%b busy=%b, required done=0 AB=00 busy=0",
                         k, done, {A, B}, busy);
            end
        end
        pos = 0;
    endtask

    initial begin
        test_reset();
        test_basic_up();
        test_zero();
        test_down();
        test_abort();
        test_abort_final();
        test_back_to_back();
        test_random();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quadenc_tx.md
QUADENC_TX -- requirements
Module: quadenc_tx

Interface
REQ-001 SHALL have parameter BITS, default 8: width of cmd_count and remaining.
REQ-002 SHALL have parameter STEP, default 2: quadrature edges emitted per detent.
REQ-003 SHALL have parameter SPACING, default 48: clk cycles between consecutive A/B edges; legal range 2..65535.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port cmd_dir  input  1  1 = up (decoder count increases), 0 = down.
REQ-009 SHALL have port cmd_count  input  BITS  number of detents to emit.
REQ-010 SHALL have port abort  input  1  stop the current command.
REQ-011 SHALL have port A  output  1  quadrature phase A, registered.
REQ-012 SHALL have port B  output  1  quadrature phase B, registered.
REQ-013 SHALL have port busy  output  1  high while a command is executing.
REQ-014 SHALL have port remaining  output  BITS+8  edges still to emit.
REQ-015 SHALL have port done  output  1  one-cycle pulse on command completion or abort.

Function
REQ-016 SHALL implement states IDLE and RUN; cmd_ready = (state == IDLE); busy = (state == RUN).
REQ-017 SHALL accept a command on a clk edge with cmd_valid && cmd_ready, latching cmd_dir and loading remaining = cmd_count*STEP, computed at full BITS+8 width without truncation.
REQ-018 SHALL, on acceptance with cmd_count = 0, stay in IDLE, keep A/B unchanged and pulse done in the following cycle.
REQ-019 SHALL, on acceptance with cmd_count > 0, enter RUN and clear the spacing timer.
REQ-020 SHALL, in RUN, toggle exactly one of A/B every SPACING cycles; the first edge occurs SPACING cycles after acceptance.
REQ-021 SHALL step the up sequence (A,B) 00->10->11->01->00 and the down sequence 00->01->11->10->00 from the current phase.
REQ-022 SHALL decrement remaining by 1 on every emitted edge.
REQ-023 SHALL, on the clk edge that emits the final edge, return to IDLE and pulse done in the next cycle; cmd_ready is high in that cycle.
REQ-024 SHALL, on abort in RUN, go to IDLE at the next clk edge with no further edge, hold A/B, zero remaining and pulse done; abort in IDLE SHALL be ignored.
REQ-025 SHALL give abort priority if abort and a final edge coincide; done pulses once.
REQ-026 SHALL ignore cmd_valid while in RUN; the command is not lost, only stalled.
REQ-027 SHALL preserve the phase between commands, so a direction reversal continues from the current (A,B).

Reset
REQ-028 SHALL, while reset is low, force state=IDLE, A=0, B=0, remaining=0, timer=0, done=0, latched dir=0, independent of clk.
REQ-029 SHALL, when reset asserts mid-command, abandon the command with no done pulse.

Structure
REQ-030 SHALL place the state encoding (IDLE, RUN) and the two-bit phase-to-(A,B) Gray table in a shared include of constants.
REQ-031 SHALL use one sub-module, quadenc_timer: a SPACING-cycle down-counter with clear input and tick output.

Verification
REQ-032 Bench SHALL cover: reset, then up cmd_count=3, STEP=2, SPACING=4 -> six edges at cycles +4,+8,...,+24; (A,B) 10,11,01,00,10,11; done at +25.
REQ-033 Bench SHALL cover: cmd_count=0 -> no A/B change, cmd_ready stays 1, done at +1.
REQ-034 Bench SHALL cover: down cmd_count=2 from phase 11 -> (A,B) 10,00,01,11, remaining 4,3,2,1,0.
REQ-035 Bench SHALL cover: abort after the 3rd of 10 edges -> A/B frozen, remaining=0, single done, cmd_ready=1 next cycle.
REQ-036 Bench SHALL cover: cmd_valid held during RUN -> second command accepted in the cycle done is high, first edge SPACING later.
REQ-037 Bench SHALL cover loopback into quaddec_f4f (BITS=8, STEP=2) from count 0: up cmd_count=5 -> count 20; down cmd_count=5 -> count 0; reset asserted mid-run -> A=B=0 immediately.
